// File: rtl/apb_slave.sv
// APB completer with NUM_REGS 32-bit registers indexed directly by PADDR.
// Each transfer is held for WAIT_STATES access cycles before PREADY rises.
module apb_slave #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [7:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [7:0]                  addr_q;
  logic                        write_q;
  logic [31:0]                 wdata_q;
  logic [NUM_REGS-1:0][31:0]   regs_q;

  logic                        addr_err;
  logic [31:0]                 rd_word;

  // Everything below keys off the setup-phase latch, never the live bus.
  assign addr_err = (32'(addr_q) >= 32'(NUM_REGS));
  assign PREADY   = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == '0);
  assign PSLVERR  = PREADY && addr_err;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == 8'(i)) rd_word = regs_q[i];
  end

  assign PRDATA = (PREADY && !write_q && !addr_err) ? rd_word : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      regs_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Only a genuine setup phase starts a transfer; a lingering
          // PSEL&PENABLE after completion is ignored here.
          if (PSEL && !PENABLE) begin
            state_q <= ACCESS;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt_q   <= CW'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_q <= IDLE;
          end else if (PENABLE) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end else begin
              state_q <= IDLE;
              if (write_q && !addr_err)
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr_q == 8'(i)) regs_q[i] <= wdata_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: one instance with one wait state and one
// zero-wait instance sharing the same bus inputs.
module tb_apb_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] prdata1, prdata0;
  logic        pready1, pready0, pslverr1, pslverr0;

  int tests = 0;
  int fails = 0;

  always #5 PCLK = ~PCLK;

  apb_slave #(.NUM_REGS(16), .WAIT_STATES(1)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  apb_slave #(.NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  // One full transfer; access-phase bus fields are scrambled to show the
  // completer uses only the setup-phase values.
  task automatic xfer(input logic ws0, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, output int waits,
                      output logic [31:0] rdata, output logic err,
                      output logic ok);
    logic rdy;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = ~a; PWRITE = ~wr; PWDATA = ~d;
    waits = 0; ok = 1'b0; rdata = '0; err = 1'b0;
    while (!ok && waits < 8) begin
      #1;
      rdy = ws0 ? pready0 : pready1;
      if (rdy) begin
        ok    = 1'b1;
        rdata = ws0 ? prdata0 : prdata1;
        err   = ws0 ? pslverr0 : pslverr1;
      end else begin
        waits++;
        @(posedge PCLK); #1;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic chk_xfer(input string name, input logic ok, input int waits,
                          input int exp_waits, input logic err, input logic exp_err,
                          input logic [31:0] rd, input logic [31:0] exp_rd);
    // deliberately inline: three separate comparisons per transfer
    tests++;
    if (ok !== 1'b1 || waits !== exp_waits) begin
      fails++;
      $display("FAIL %s ready: ok=%0b waits=%0d expected waits=%0d", name, ok, waits, exp_waits);
    end
    tests++;
    if (err !== exp_err) begin
      fails++;
      $display("FAIL %s pslverr: got %0b expected %0b", name, err, exp_err);
    end
    tests++;
    if (rd !== exp_rd) begin
      fails++;
      $display("FAIL %s prdata: got %h expected %h", name, rd, exp_rd);
    end
  endtask

  int          w;
  logic [31:0] rd;
  logic        er, ok;

  task automatic test_reset();
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    #23;
    tests++;
    if ({pready1, pslverr1, prdata1, pready0, pslverr0, prdata0} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%0b err=%0b rd=%h expected all 0",
               pready1, pslverr1, prdata1);
    end
    PRESETn = 1'b1;
    @(posedge PCLK);
  endtask

  task automatic test_write_read();
    xfer(0, 1, 8'h02, 32'hCAFEBABE, w, rd, er, ok);
    chk_xfer("wr02", ok, w, 1, er, 0, rd, 32'h0);
    xfer(0, 0, 8'h02, 32'h0, w, rd, er, ok);
    chk_xfer("rd02", ok, w, 1, er, 0, rd, 32'hCAFEBABE);
  endtask

  task automatic test_error();
    xfer(0, 1, 8'h20, 32'h0BADF00D, w, rd, er, ok);
    chk_xfer("wr20_err", ok, w, 1, er, 1, rd, 32'h0);
    xfer(0, 0, 8'h20, 32'h0, w, rd, er, ok);
    chk_xfer("rd20_err", ok, w, 1, er, 1, rd, 32'h0);
    xfer(0, 1, 8'h0F, 32'h5A5A5A5A, w, rd, er, ok);
    chk_xfer("wr0F_last", ok, w, 1, er, 0, rd, 32'h0);
    xfer(0, 0, 8'h0F, 32'h0, w, rd, er, ok);
    chk_xfer("rd0F_last", ok, w, 1, er, 0, rd, 32'h5A5A5A5A);
    xfer(0, 0, 8'h10, 32'h0, w, rd, er, ok);
    chk_xfer("rd10_err", ok, w, 1, er, 1, rd, 32'h0);
    xfer(0, 0, 8'h02, 32'h0, w, rd, er, ok);
    chk_xfer("rd02_after_err", ok, w, 1, er, 0, rd, 32'hCAFEBABE);
  endtask

  task automatic test_second_reg();
    xfer(0, 1, 8'h05, 32'hFEEDBEEF, w, rd, er, ok);
    chk_xfer("wr05", ok, w, 1, er, 0, rd, 32'h0);
    xfer(0, 0, 8'h05, 32'h0, w, rd, er, ok);
    chk_xfer("rd05", ok, w, 1, er, 0, rd, 32'hFEEDBEEF);
    xfer(0, 0, 8'h02, 32'h0, w, rd, er, ok);
    chk_xfer("rd02_again", ok, w, 1, er, 0, rd, 32'hCAFEBABE);
  endtask

  task automatic test_abort();
    int hi = 0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PADDR = 8'h03; PWRITE = 1; PWDATA = 32'hABCD1234;
    @(posedge PCLK); #1;
    PSEL = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (pready1 || pready0) hi++;
      @(posedge PCLK); #1;
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL abort_pready: got %0d high samples expected 0", hi);
    end
    xfer(0, 0, 8'h03, 32'h0, w, rd, er, ok);
    chk_xfer("rd03_abort", ok, w, 1, er, 0, rd, 32'h0);
  endtask

  task automatic test_idle_enable_ignored();
    int hi = 0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 1; PADDR = 8'h07; PWRITE = 1; PWDATA = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      #1; if (pready1 || pready0) hi++;
      @(posedge PCLK); #1;
    end
    PSEL = 0; PENABLE = 0;
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL idle_enable_pready: got %0d high samples expected 0", hi);
    end
    xfer(0, 0, 8'h07, 32'h0, w, rd, er, ok);
    chk_xfer("rd07_idle", ok, w, 1, er, 0, rd, 32'h0);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PADDR = 8'h06; PWRITE = 1; PWDATA = 32'h11112222;
    @(posedge PCLK); #1;
    PENABLE = 1;
    // one wait cycle, ready cycle, then three cycles of lingering enable
    for (int i = 0; i < 5; i++) begin
      #1; if (pready1) pulses++;
      @(posedge PCLK); #1;
      PWDATA = 32'h33334444;
    end
    PSEL = 0; PENABLE = 0;
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL linger_pulses: got %0d expected 1", pulses);
    end
    xfer(0, 0, 8'h06, 32'h0, w, rd, er, ok);
    chk_xfer("rd06_linger", ok, w, 1, er, 0, rd, 32'h11112222);
  endtask

  task automatic test_reset_midxfer();
    int hi = 0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PADDR = 8'h04; PWRITE = 1; PWDATA = 32'h44440000;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1; PRESETn = 1'b0;
    #1;
    tests++;
    if (pready1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_pready: got %0b expected 0", pready1);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    // bus still shows access phase, but the aborted transfer must not resume
    for (int i = 0; i < 2; i++) begin
      #1; if (pready1 || pready0) hi++;
      @(posedge PCLK); #1;
    end
    PSEL = 0; PENABLE = 0;
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL reset_resume_pready: got %0d high samples expected 0", hi);
    end
    xfer(0, 0, 8'h04, 32'h0, w, rd, er, ok);
    chk_xfer("rd04_reset", ok, w, 1, er, 0, rd, 32'h0);
    xfer(0, 0, 8'h02, 32'h0, w, rd, er, ok);
    chk_xfer("rd02_reset", ok, w, 1, er, 0, rd, 32'h0);
    xfer(0, 0, 8'h05, 32'h0, w, rd, er, ok);
    chk_xfer("rd05_reset", ok, w, 1, er, 0, rd, 32'h0);
  endtask

  task automatic test_zero_wait();
    xfer(1, 1, 8'h09, 32'h99990009, w, rd, er, ok);
    chk_xfer("ws0_wr09", ok, w, 0, er, 0, rd, 32'h0);
    xfer(1, 0, 8'h09, 32'h0, w, rd, er, ok);
    chk_xfer("ws0_rd09", ok, w, 0, er, 0, rd, 32'h99990009);
    xfer(1, 0, 8'h30, 32'h0, w, rd, er, ok);
    chk_xfer("ws0_rd30_err", ok, w, 0, er, 1, rd, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_second_reg();
    test_abort();
    test_idle_enable_ignored();
    test_back_to_back();
    test_reset_midxfer();
    test_zero_wait();
    repeat (2) @(posedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
